// File: rtl/fairy_mem_stage_pkg.sv
// Shared MIPS-I constants for the fairy MEM stage: load/store opcodes, exception
// codes, FSM encodings and the WB-facing output record.
package fairy_mem_stage_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  typedef enum logic [2:0] {LD_B, LD_BU, LD_H, LD_HU, LD_W} ld_type_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] badvaddr;
  } wb_out_t;
endpackage

// File: rtl/fairy_load_align.sv
// Picks the addressed byte/half out of the RAM word and sign/zero-extends it.
module fairy_load_align
  import fairy_mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  ld_type_e    ltype_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ltype_i)
      LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data_o = {24'd0, byte_sel};
      LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/fairy_mem_stage.sv
// fairy MEM stage: decodes loads/stores, drives the data RAM through a two-state
// request FSM, raises AdEL/AdES/Ov and registers the result towards WB.
module fairy_mem_stage
  import fairy_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        overflow_i,
  input  logic        exception_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_ack_i,
  input  logic [31:0] data_rdata_i,
  output logic        stall_o,
  output logic [31:0] data_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        exc_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] badvaddr_o
);
  logic        state_q, state_d;
  logic        discard_q, discard_d;
  wb_out_t     out_q, out_d, res;
  logic        is_load, is_store, misal, mem_ok, req, stall;
  ld_type_e    ltype;
  logic [31:0] ld_data;

  always_comb begin
    is_load      = 1'b0;
    is_store     = 1'b0;
    misal        = 1'b0;
    ltype        = LD_W;
    data_be_o    = 4'b0000;
    data_wdata_o = op1_i;
    case (inst_i[31:26])
      OP_LB:  begin is_load = 1'b1; ltype = LD_B; end
      OP_LBU: begin is_load = 1'b1; ltype = LD_BU; end
      OP_LH:  begin is_load = 1'b1; ltype = LD_H;  misal = data_i[0]; end
      OP_LHU: begin is_load = 1'b1; ltype = LD_HU; misal = data_i[0]; end
      OP_LW:  begin is_load = 1'b1; ltype = LD_W;  misal = |data_i[1:0]; end
      OP_SB: begin
        is_store     = 1'b1;
        data_be_o    = 4'b0001 << data_i[1:0];
        data_wdata_o = {4{op1_i[7:0]}};
      end
      OP_SH: begin
        is_store     = 1'b1;
        misal        = data_i[0];
        data_be_o    = data_i[1] ? 4'b1100 : 4'b0011;
        data_wdata_o = {2{op1_i[15:0]}};
      end
      OP_SW: begin
        is_store  = 1'b1;
        misal     = |data_i[1:0];
        data_be_o = 4'b1111;
      end
      default: ;
    endcase
  end

  assign mem_ok      = (is_load | is_store) & ~misal & ~overflow_i;
  assign data_wr_o   = is_store;
  assign data_addr_o = {data_i[31:2], 2'b00};

  fairy_load_align u_align (
    .rdata_i (data_rdata_i),
    .addr_i  (data_i[1:0]),
    .ltype_i (ltype),
    .data_o  (ld_data)
  );

  // Faulting instructions are killed (inst=0) so WB never commits them.
  always_comb begin
    res.inst     = inst_i;
    res.pc       = pc_i;
    res.data     = is_store ? 32'd0 : (is_load ? ld_data : data_i);
    res.exc      = 1'b0;
    res.code     = 5'd0;
    res.badvaddr = 32'd0;
    if (overflow_i) begin
      res.exc  = 1'b1;
      res.code = EXC_OV;
      res.inst = 32'd0;
      res.data = 32'd0;
    end else if ((is_load | is_store) & misal) begin
      res.exc      = 1'b1;
      res.code     = is_load ? EXC_ADEL : EXC_ADES;
      res.badvaddr = data_i;
      res.inst     = 32'd0;
      res.data     = 32'd0;
    end
  end

  // A flush during WAIT cannot cancel the bus cycle; remember it and drop the ack'd result.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req       = 1'b0;
    stall     = 1'b0;
    out_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (!exception_i) begin
          if (mem_ok) begin
            req = 1'b1;
            if (data_ack_i) out_d = res;
            else begin
              stall   = 1'b1;
              state_d = S_WAIT;
            end
          end else begin
            out_d = res;
          end
        end
      end
      default: begin
        req = 1'b1;
        if (data_ack_i) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          out_d     = (discard_q | exception_i) ? '0 : res;
        end else begin
          stall = 1'b1;
          if (exception_i) discard_d = 1'b1;
        end
      end
    endcase
  end

  assign data_req_o = req & reset_n;
  assign stall_o    = stall & reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      out_q     <= out_d;
    end
  end

  assign data_o     = out_q.data;
  assign inst_o     = out_q.inst;
  assign pc_o       = out_q.pc;
  assign exc_o      = out_q.exc;
  assign exc_code_o = out_q.code;
  assign badvaddr_o = out_q.badvaddr;
endmodule
